// File: rtl/iob_native_sram_resp.sv
// Native-bus SRAM responder with byte-enable writes; IOB_SRAM_RANGE_CHK_EN adds an err output for accesses beyond the SRAM.
// Latency: ready 1+WAIT_STATES cycles after valid is sampled, for one cycle; one access per 2+WAIT_STATES cycles.
// Backpressure: requests are taken only in IDLE; ready is registered so the initiator can mask valid with ~ready.
module iob_native_sram_resp #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 12,
    parameter int WAIT_STATES = 0,
    localparam int STRB_W     = DATA_W / 8,
    localparam int REQ_W      = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W     = DATA_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REQ_W-1:0]  req,
    output logic [RESP_W-1:0] resp
`ifdef IOB_SRAM_RANGE_CHK_EN
    ,
    output logic              err
`endif
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic                  req_vld;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [STRB_W-1:0]     req_wstrb;
    logic [MEM_ADDR_W-1:0] req_idx;
    logic                  req_oor;
    logic                  unused_addr;

    logic [MEM_ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  oor_q;

    logic [MEM_ADDR_W-1:0] acc_idx;
    logic [DATA_W-1:0]     acc_wdata;
    logic [STRB_W-1:0]     acc_wstrb;
    logic                  acc_oor;
    logic                  acc_go;
    logic                  acc_wr;

    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

    assign req_vld     = req[REQ_W-1];
    assign req_addr    = req[REQ_W-2 -: ADDR_W];
    assign req_wdata   = req[DATA_W+STRB_W-1 -: DATA_W];
    assign req_wstrb   = req[STRB_W-1:0];
    assign req_idx     = req_addr[MEM_ADDR_W+1:2];
    assign unused_addr = ^req_addr;

`ifdef IOB_SRAM_RANGE_CHK_EN
    assign req_oor = |(req_addr >> (MEM_ADDR_W + 2));
`else
    assign req_oor = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_vld) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = ACK;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            oor_q   <= 1'b0;
        end else if (state == IDLE && req_vld) begin
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            oor_q   <= req_oor;
        end
    end

    // With no wait states ACK is entered straight from IDLE, so the access uses the live request.
    assign acc_idx   = (state == IDLE) ? req_idx   : idx_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;
    assign acc_oor   = (state == IDLE) ? req_oor   : oor_q;
    assign acc_go    = (state_nxt == ACK);
    assign acc_wr    = |acc_wstrb;

    always_ff @(posedge clk) begin
        if (acc_go && acc_wr && !acc_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            rdata_q <= (acc_go && !acc_wr && !acc_oor) ? mem[acc_idx] : '0;
            ready_q <= acc_go;
        end
    end

`ifdef IOB_SRAM_RANGE_CHK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err <= 1'b0;
        else         err <= acc_go && acc_oor;
    end
`endif

    assign resp = {rdata_q, ready_q};

endmodule

// File: tb/tb_iob_native_sram_resp.sv
// Bench for iob_native_sram_resp: two instances (0 and 3 wait states) driven by directed vectors, checked by a scoreboard monitor.
module tb_iob_native_sram_resp;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic [1:0]  rst_n;
    logic        v_raw  [2];
    logic [31:0] addr_r [2];
    logic [31:0] wdat_r [2];
    logic [3:0]  strb_r [2];
    logic [68:0] req_b  [2];
    logic [32:0] resp_b [2];
`ifdef IOB_SRAM_RANGE_CHK_EN
    logic        err_b  [2];
`endif

    exp_t sbq[$];
    exp_t m_e;
    int   cyc;
    int   nvec;
    int   nmis;

    // Initiator masks valid with ~ready, as the CPU wrapper does.
    assign req_b[0] = {v_raw[0] & ~resp_b[0][0], addr_r[0], wdat_r[0], strb_r[0]};
    assign req_b[1] = {v_raw[1] & ~resp_b[1][0], addr_r[1], wdat_r[1], strb_r[1]};

    iob_native_sram_resp #(.WAIT_STATES(WS0)) u_dut0 (
        .clk    (clk),
        .resetn (rst_n[0]),
        .req    (req_b[0]),
        .resp   (resp_b[0])
`ifdef IOB_SRAM_RANGE_CHK_EN
        ,
        .err    (err_b[0])
`endif
    );

    iob_native_sram_resp #(.WAIT_STATES(WS1)) u_dut1 (
        .clk    (clk),
        .resetn (rst_n[1]),
        .req    (req_b[1]),
        .resp   (resp_b[1])
`ifdef IOB_SRAM_RANGE_CHK_EN
        ,
        .err    (err_b[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | (i * 32'h11);
    endfunction

    // Monitor: every ready pulse must match the head of the scoreboard, in data and timing.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (resp_b[d][0]) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_ready: dut %0d got ready=1 expected no response (cycle %0d)", d, cyc);
                end else begin
                    m_e = sbq.pop_front();
                    chk("resp_dut", d, m_e.d);
                    chk("resp_rdata", resp_b[d][32:1], m_e.rdata);
                    chk("resp_cycle", cyc, m_e.cyc);
`ifdef IOB_SRAM_RANGE_CHK_EN
                    chk("resp_err", {31'd0, err_b[d]}, {31'd0, m_e.err});
`endif
                end
            end else begin
                chk("rdata_idle", resp_b[d][32:1], 32'h0);
`ifdef IOB_SRAM_RANGE_CHK_EN
                chk("err_idle", {31'd0, err_b[d]}, 32'h0);
`endif
            end
        end
    end

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] er, input logic ee, input bit garble);
        exp_t e;
        bit   got;
        @(negedge clk);
        addr_r[d] = a;
        wdat_r[d] = wd;
        strb_r[d] = ws;
        v_raw[d]  = 1'b1;
        e.d     = d;
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + 1 + ((d == 0) ? WS0 : WS1);
        sbq.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (resp_b[d][0]) begin
                got = 1'b1;
            end else if (garble) begin
                addr_r[d] = 32'h1C;
                wdat_r[d] = 32'hBAD0_BAD0;
                strb_r[d] = 4'hF;
            end
        end
        v_raw[d] = 1'b0;
        if (!got) begin
            nvec++;
            nmis++;
            $display("FAIL timeout: dut %0d addr %h got no ready expected ready within 40 cycles", d, a);
        end
    endtask

    task automatic preload(input int d);
        for (int i = 0; i < 8; i++) issue(d, 32'(i * 4), pat(i), 4'hF, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic b2b_reads(input int d);
        for (int i = 0; i < 8; i++) issue(d, 32'(i * 4), 32'h0, 4'h0, pat(i), 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        cyc   = 0;
        nvec  = 0;
        nmis  = 0;
        rst_n = 2'b00;
        for (int d = 0; d < 2; d++) begin
            v_raw[d]  = 1'b0;
            addr_r[d] = 32'h0;
            wdat_r[d] = 32'h0;
            strb_r[d] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", {31'd0, resp_b[d][0]}, 32'h0);
            chk("reset_rdata", resp_b[d][32:1], 32'h0);
        end
        rst_n = 2'b11;

        // Zero wait states: full write, read-back, byte-enable merge.
        issue(0, 32'h10, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, 1'b0);
        issue(0, 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0, 1'b0);
        issue(0, 32'h10, 32'hFFFF_FFFF, 4'h6, 32'h0, 1'b0, 1'b0);
        issue(0, 32'h10, 32'h0, 4'h0, 32'hA5FF_FF34, 1'b0, 1'b0);
        preload(0);
        b2b_reads(0);

        // Upper address bits: error with range check, aliasing without.
`ifdef IOB_SRAM_RANGE_CHK_EN
        issue(0, 32'h4000, 32'h1111_1111, 4'hF, 32'h0, 1'b1, 1'b0);
        issue(0, 32'h0000, 32'h0, 4'h0, pat(0), 1'b0, 1'b0);
        issue(0, 32'h4000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
`else
        issue(0, 32'h4000, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b0);
        issue(0, 32'h0000, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1'b0);
        issue(0, 32'h4000, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1'b0);
`endif

        // Three wait states: valid held with a different request must not be re-captured.
        preload(1);
        issue(1, 32'h20, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
        issue(1, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
        b2b_reads(1);

        // Reset during WAIT abandons the write.
        @(negedge clk);
        addr_r[1] = 32'h20;
        wdat_r[1] = 32'hDEAD_BEEF;
        strb_r[1] = 4'hF;
        v_raw[1]  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        v_raw[1] = 1'b0;
        #1;
        chk("rst_wait_ready", {31'd0, resp_b[1][0]}, 32'h0);
        chk("rst_wait_rdata", resp_b[1][32:1], 32'h0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;

        // Reset during ACK drops ready without waiting for a clock edge.
        issue(1, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
        rst_n[1] = 1'b0;
        #1;
        chk("rst_ack_ready", {31'd0, resp_b[1][0]}, 32'h0);
        chk("rst_ack_rdata", resp_b[1][32:1], 32'h0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        issue(1, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/iob_native_sram_resp.md
Name: iob_native_sram_resp

Overview:
- Responder (slave) end of the native concatenated req/resp bus that the CPU wrapper drives as initiator.
- Decodes `valid`/`address`/`wdata`/`wstrb` from the request bus and serves them from an internal word-organised SRAM with byte-enable writes.
- Returns `rdata`/`ready` on the response bus after a programmable number of wait states.
- Used as boot/firmware RAM and as a latency-configurable memory model behind the instruction or data bus.

Parameters:
- ADDR_W, 32: request address width; must match the `ADDR_W` macro.
- DATA_W, 32: data width; wstrb width is DATA_W/8.
- MEM_ADDR_W, 12: SRAM depth in words, as log2 (4 KiW default).
- WAIT_STATES, 0: extra cycles inserted before `ready` (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  `REQ_W  native request bus {valid, address, wdata, wstrb}; fields accessed with the interconnect field macros at index 0.
- resp  output  `RESP_W  native response bus {rdata, ready}.
- err  output  1  out-of-range pulse; present only with IOB_SRAM_RANGE_CHK_EN.

Behaviour:
- Reset, asynchronous on resetn low:
  - FSM to IDLE, ready=0, rdata=0, wait counter=0, captured request registers=0.
  - SRAM contents are not reset.
- Word index = address[MEM_ADDR_W+1:2]. Bits [1:0] are ignored (no misalignment handling).
- Access type: write if wstrb!=0, read if wstrb==0.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on valid=1, capture word index, wdata and wstrb.
    - If WAIT_STATES==0, go to ACK.
    - Otherwise load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement counter each cycle; go to ACK when counter==0.
  - ACK: memory access happens on entry (the transition edge into ACK). Hold ready=1 for exactly one cycle, then return to IDLE.
- ready is a registered output, never combinational from valid.
  - Required because the initiator masks valid with ~ready combinationally; a combinational ready would form a loop.
- Latency: valid sampled in cycle 0 gives ready=1 in cycle 1+WAIT_STATES.
  - Back-to-back throughput: one access per 2+WAIT_STATES cycles.
- Read: rdata = SRAM[index], registered, valid only while ready=1.
- Write:
  - For each i with wstrb[i]=1, SRAM[index] byte i = wdata byte i.
  - Bytes with wstrb[i]=0 are unchanged.
  - rdata=0 in the ack cycle.
- rdata returns to 0 in every cycle where ready=0.
- valid in WAIT or ACK: ignored, no second capture. The request is taken only from IDLE.
- valid low in IDLE: no state change, no memory access.
- A new request in the cycle immediately after ACK is accepted normally; there is no dead cycle beyond ACK.
- Reset asserted in WAIT or ACK:
  - The pending access is abandoned; a write that has not yet reached ACK entry is not performed.
  - ready drops asynchronously.
- Address bits above MEM_ADDR_W+1 (without the macro): ignored, so the memory aliases across the address space.
- Counter width: max(1, clog2(WAIT_STATES+1)).

Optional Feature:
- Macro: IOB_SRAM_RANGE_CHK_EN.
- Defined:
  - Adds the err output and range logic.
  - The request is out of range if any captured address bit above MEM_ADDR_W+1 is 1.
  - Out-of-range accesses still complete the handshake with normal latency, so the initiator never hangs.
  - Out-of-range write: no memory update.
  - Out-of-range read: rdata=0.
  - err=1 for the same single cycle as ready; err=0 otherwise and on reset.
- Undefined:
  - No err port.
  - Upper address bits are ignored, so addresses alias.

Test Plan:
- WAIT_STATES=0: write addr 0x10, wdata 0xA5A5_1234, wstrb 0xF. Read addr 0x10 → ready exactly 1 cycle after valid, rdata=0xA5A5_1234, ready high for exactly one cycle.
- Byte enables: after the write above, write addr 0x10, wdata 0xFFFF_FFFF, wstrb 0x6. Read → rdata=0xA5FF_FF34.
- WAIT_STATES=3: read request in cycle 0 → ready=1 in cycle 4 only. valid held high through cycles 1-3 with a different address causes no second access.
- Back-to-back: initiator masks valid with ~ready and issues 8 consecutive reads (addr 0x0..0x1C) → 8 ready pulses at a fixed 2+WAIT_STATES cycle spacing, correct data each.
- Reset mid-op: issue write 0xDEAD_BEEF to addr 0x20 with WAIT_STATES=3; drop resetn in cycle 2 → ready=0 and rdata=0 immediately. After release, read addr 0x20 → old value, write not performed.
- IOB_SRAM_RANGE_CHK_EN, MEM_ADDR_W=12: write 0x1111_1111 to addr 0x4000; read addr 0x0000 and 0x4000 → err pulses with ready on the 0x4000 accesses only, rdata=0 for 0x4000, addr 0x0 unchanged. Without the macro, the same sequence aliases: read addr 0x0 = 0x1111_1111.
